flash_ctrl_info_sched: RTL and testbench
========================================

Name: flash_ctrl_info_sched

Overview:
- Schedules info-partition page accesses from several requesters onto the single flash phy info-access port.
- Round-robin arbitration between requesters.
- Each request is checked against the per-type page count (InfoTypeSize) before it reaches the phy. Out-of-range requests are rejected locally with an error.
- Sits between the flash_ctrl requesters (software, key manager, life-cycle) and the phy command interface.

Parameters:
- NumReq, 3, number of requesters (≥2).
- TimeoutCycles, 1024, phy watchdog limit in clocks. Used only with the optional feature.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- req_i  input  NumReq  per-requester request level; held until the matching done_o.
- type_i  input  NumReq*TypeW  info type per requester; slot r at bits [r*TypeW +: TypeW].
- page_i  input  NumReq*PageW  page index per requester; same packing.
- op_i  input  NumReq*2  operation per requester (info_op_e: READ, PROG, ERASE).
- done_o  output  NumReq  one-cycle completion pulse for the selected requester.
- err_o  output  NumReq  error qualifier, valid only while the same bit of done_o is high.
- phy_req_o  output  1  command valid to phy.
- phy_type_o  output  TypeW  latched type.
- phy_page_o  output  PageW  latched page.
- phy_op_o  output  2  latched op.
- phy_ack_i  input  1  phy accepts the command.
- phy_done_i  input  1  phy operation complete (pulse).
- phy_err_i  input  1  phy error, qualified by phy_done_i.
- busy_o  output  1  high in every state except IDLE.
- timeout_o  output  1  sticky watchdog alert.

Behaviour:
- Reset: state IDLE; RR pointer 0; latched idx/type/page/op 0.
  - Outputs at reset: done_o, err_o, phy_req_o, busy_o and timeout_o all 0; phy_* buses 0.
  - Reset asserted mid-operation aborts immediately; phy_req_o drops asynchronously.
- FSM states: IDLE, CHECK, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_i bit is set, select the first set index at or after the pointer, wrapping modulo NumReq.
  - Latch idx, type, page and op; go to CHECK.
- CHECK (one cycle): valid = (type < InfoTypes) && (page < InfoTypeSize[type]).
  - Invalid: go to RESP with err=1; the phy is never touched.
  - Valid: go to ISSUE.
- ISSUE: phy_req_o=1 and phy_* driven from the latches, held stable until phy_ack_i. On ack go to WAIT (phy_req_o low next cycle).
- WAIT: on phy_done_i go to RESP, latching err=phy_err_i.
  - phy_done_i outside WAIT is ignored.
- RESP (one cycle):
  - done_o[idx]=1 and err_o[idx]=err.
  - Pointer becomes (idx+1) mod NumReq; go to IDLE.
- Latency:
  - Invalid request: req seen in IDLE at cycle t, done at t+2.
  - Valid request with same-cycle ack and done-in-first-WAIT-cycle: done at t+4.
- Requester obligations:
  - Deassert req in the cycle after done, otherwise it is re-arbitrated.
  - Dropping req mid-operation does not cancel it; done still pulses.
- Request inputs are sampled only in IDLE; later changes have no effect on an accepted request.
- Only one operation is outstanding at a time. No pipelining.

Optional Feature:
- Macro: FLASH_CTRL_INFO_SCHED_TIMEOUT_EN.
- Defined:
  - A counter (width $clog2(TimeoutCycles+1)) clears on entry to ISSUE and increments in ISSUE and WAIT.
  - On reaching TimeoutCycles: go to RESP with err=1, deassert phy_req_o, and set timeout_o sticky until reset.
  - While timeout_o=1, every further request is rejected in CHECK with err=1.
- Undefined: no counter; the FSM waits indefinitely; timeout_o is tied 0.

Decomposition:
- flash_ctrl_pkg holds the shared definitions:
  - InfoTypes, InfoTypeSize[], InfosPerBank.
  - TypeW = $clog2(InfoTypes) and PageW = $clog2(InfosPerBank).
  - info_op_e and the FSM state enum.
- One sub-module: flash_ctrl_rr_arb (NumReq-wide round-robin picker: req vector and pointer in; one-hot grant and index out; combinational).

Test Plan:
- Single valid request: req0, type=0, page=9 → phy_req_o with page 9; ack+done with phy_err_i=0 → done_o=001, err_o=000, at t+4.
- Out-of-range request: req1, type=1, page=1 (InfoTypeSize=1) → done_o=010, err_o=010 at t+2; phy_req_o never asserts. Repeat with type=3 → same.
- Fairness: req=111 held, each released after its done → grant order 0,1,2,0. Then pointer=1 with req=101 → grants 2 then 0.
- Phy error and backpressure: ack delayed 5 cycles → phy_req_o and phy_page_o stable throughout; phy_err_i=1 on done → err_o set for that requester.
- Reset mid-WAIT: rst_i pulsed → phy_req_o, busy_o and done_o are 0 immediately; next request is granted from index 0.
- With FLASH_CTRL_INFO_SCHED_TIMEOUT_EN and TimeoutCycles=8: no ack → done with err=1 after 8 cycles and timeout_o=1; a following valid request is rejected with err=1 and the phy is untouched.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared definitions for the flash controller info-partition scheduler:
// info page geometry, operation encoding and scheduler FSM states.
package flash_ctrl_pkg;

  localparam int unsigned InfoTypes    = 3;
  localparam int unsigned InfosPerBank = 10;
  localparam int unsigned InfoTypeSize [InfoTypes] = '{InfosPerBank, 1, 2};
  localparam int unsigned TypeW        = $clog2(InfoTypes);
  localparam int unsigned PageW        = $clog2(InfosPerBank);

  typedef enum logic [1:0] {
    InfoOpRead  = 2'd0,
    InfoOpProg  = 2'd1,
    InfoOpErase = 2'd2
  } info_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StIssue,
    StWait,
    StResp
  } sched_state_e;

  // Type values beyond InfoTypes never match a table entry, so they are invalid too.
  function automatic logic info_page_valid(input logic [TypeW-1:0] typ,
                                           input logic [PageW-1:0] page);
    logic ok;
    ok = 1'b0;
    for (int unsigned t = 0; t < InfoTypes; t++) begin
      if ((32'(typ) == t) && (32'(page) < InfoTypeSize[t])) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/flash_ctrl_rr_arb.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping modulo NumReq.
module flash_ctrl_rr_arb #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_ptr,
  output logic [NumReq-1:0] o_gnt,
  output logic [IdxW-1:0]   o_idx
);

  int w_cand;

  // Walk from the farthest candidate back to the pointer so the nearest set request wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_cand = 0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      w_cand = (int'(i_ptr) + k) % int'(NumReq);
      for (int j = 0; j < int'(NumReq); j++) begin
        if ((j == w_cand) && i_req[j]) begin
          o_gnt    = '0;
          o_gnt[j] = 1'b1;
          o_idx    = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/flash_ctrl_info_sched.sv
// Round-robin scheduler of info-partition page accesses onto the single flash phy port.
// Optional phy watchdog enabled by defining FLASH_CTRL_INFO_SCHED_TIMEOUT_EN.
module flash_ctrl_info_sched
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned NumReq        = 3,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [NumReq*TypeW-1:0] type_i,
  input  logic [NumReq*PageW-1:0] page_i,
  input  logic [NumReq*2-1:0]     op_i,
  output logic [NumReq-1:0]       done_o,
  output logic [NumReq-1:0]       err_o,
  output logic                    phy_req_o,
  output logic [TypeW-1:0]        phy_type_o,
  output logic [PageW-1:0]        phy_page_o,
  output logic [1:0]              phy_op_o,
  input  logic                    phy_ack_i,
  input  logic                    phy_done_i,
  input  logic                    phy_err_i,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  sched_state_e      r_state, w_state_nxt;
  logic [IdxW-1:0]   r_ptr, r_idx, w_arb_idx;
  logic [NumReq-1:0] w_gnt;
  logic [TypeW-1:0]  r_type;
  logic [PageW-1:0]  r_page;
  info_op_e          r_op;
  logic              r_err;
  logic              w_any, w_valid, w_to_hit, w_timeout;

  flash_ctrl_rr_arb #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_arb (
    .i_req(req_i),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_arb_idx)
  );

  assign w_any = |w_gnt;

`ifdef FLASH_CTRL_INFO_SCHED_TIMEOUT_EN
  logic [CntW-1:0] r_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_state inside {StIssue, StWait}) && (r_cnt == CntW'(TimeoutCycles));

  // Clearing in CHECK makes every phy command start with a fresh watchdog budget.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == StCheck) r_cnt <= '0;
      else if ((r_state inside {StIssue, StWait}) && !w_to_hit) r_cnt <= r_cnt + CntW'(1);
      if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
`else
  logic [CntW-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
  assign w_to_hit     = 1'b0;
  assign w_timeout    = 1'b0;
`endif

  assign w_valid = info_page_valid(r_type, r_page) && !w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    phy_req_o   = 1'b0;
    done_o      = '0;
    err_o       = '0;
    unique case (r_state)
      StIdle:  if (w_any) w_state_nxt = StCheck;
      StCheck: w_state_nxt = w_valid ? StIssue : StResp;
      StIssue: begin
        phy_req_o = !w_to_hit;
        if (w_to_hit)       w_state_nxt = StResp;
        else if (phy_ack_i) w_state_nxt = StWait;
      end
      StWait:  if (w_to_hit || phy_done_i) w_state_nxt = StResp;
      StResp: begin
        done_o[r_idx] = 1'b1;
        err_o[r_idx]  = r_err;
        w_state_nxt   = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Request fields are captured once in IDLE so later input changes cannot disturb the command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr  <= '0;
      r_idx  <= '0;
      r_type <= '0;
      r_page <= '0;
      r_op   <= InfoOpRead;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_idx  <= w_arb_idx;
            r_type <= type_i[w_arb_idx*TypeW +: TypeW];
            r_page <= page_i[w_arb_idx*PageW +: PageW];
            r_op   <= info_op_e'(op_i[w_arb_idx*2 +: 2]);
          end
        end
        StCheck: r_err <= !w_valid;
        StIssue: if (w_to_hit) r_err <= 1'b1;
        StWait: begin
          if (w_to_hit)        r_err <= 1'b1;
          else if (phy_done_i) r_err <= phy_err_i;
        end
        StResp:  r_ptr <= (r_idx == IdxW'(NumReq - 1)) ? '0 : r_idx + IdxW'(1);
        default: ;
      endcase
    end
  end

  assign phy_type_o = r_type;
  assign phy_page_o = r_page;
  assign phy_op_o   = r_op;
  assign busy_o     = (r_state != StIdle);
  assign timeout_o  = w_timeout;

endmodule

// File: tb/tb_flash_ctrl_info_sched.sv
// Bench for flash_ctrl_info_sched: vector table, scoreboard of expected completions and
// hand-written fairness/reset sequences. Define FLASH_CTRL_INFO_SCHED_TIMEOUT_EN for the watchdog case.
module tb_flash_ctrl_info_sched;
  import flash_ctrl_pkg::*;

  localparam int unsigned NumReq        = 3;
  localparam int unsigned TimeoutCycles = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NumReq-1:0]       req = '0;
  logic [NumReq*TypeW-1:0] typeBus = '0;
  logic [NumReq*PageW-1:0] pageBus = '0;
  logic [NumReq*2-1:0]     opBus = '0;
  logic                    phyAck = 1'b0;
  logic                    phyDone = 1'b0;
  logic                    phyErr = 1'b0;
  logic [NumReq-1:0]       doneO, errO;
  logic                    phyReq, busy, timeoutO;
  logic [TypeW-1:0]        phyType;
  logic [PageW-1:0]        phyPage;
  logic [1:0]              phyOp;

  flash_ctrl_info_sched #(
    .NumReq       (NumReq),
    .TimeoutCycles(TimeoutCycles)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .type_i    (typeBus),
    .page_i    (pageBus),
    .op_i      (opBus),
    .done_o    (doneO),
    .err_o     (errO),
    .phy_req_o (phyReq),
    .phy_type_o(phyType),
    .phy_page_o(phyPage),
    .phy_op_o  (phyOp),
    .phy_ack_i (phyAck),
    .phy_done_i(phyDone),
    .phy_err_i (phyErr),
    .busy_o    (busy),
    .timeout_o (timeoutO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [TypeW-1:0] typ;
    logic [PageW-1:0] page;
    logic [1:0]       op;
    int               ackDelay;
    bit               phyErr;
    bit               expErr;
    bit               expTouch;
    int               expLat;
  } vec_t;

  typedef struct {
    int               idx;
    bit               err;
    bit               touch;
    int               lat;
    int               start;
    logic [TypeW-1:0] typ;
    logic [PageW-1:0] page;
    logic [1:0]       op;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[8];
  int   compared = 0;
  int   mismatched = 0;
  int   cycleNo = 0;
  int   doneCount = 0;
  int   ackDelay = 0;
  int   ackCnt = 0;
  bit   phyErrVal = 1'b0;
  bit   noDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic pushExp(input int idx, input bit err, input bit touch, input int lat);
    exp_t e;
    e.idx   = idx;
    e.err   = err;
    e.touch = touch;
    e.lat   = lat;
    e.start = cycleNo;
    e.typ   = typeBus[idx*TypeW +: TypeW];
    e.page  = pageBus[idx*PageW +: PageW];
    e.op    = opBus[idx*2 +: 2];
    sbQ.push_back(e);
  endtask

  // One clock: sample at the falling edge, run the phy responder, then score any completion.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cycleNo++;
    if (phyAck) begin
      phyAck = 1'b0;
      if (!noDone) begin
        phyDone = 1'b1;
        phyErr  = phyErrVal;
      end
    end else begin
      phyDone = 1'b0;
      phyErr  = 1'b0;
      if (phyReq) begin
        if (sbQ.size() > 0) begin
          checkOutput("phy_req_allowed", 32'(phyReq), 32'(sbQ[0].touch));
          if (sbQ[0].touch) begin
            checkOutput("phy_type", 32'(phyType), 32'(sbQ[0].typ));
            checkOutput("phy_page", 32'(phyPage), 32'(sbQ[0].page));
            checkOutput("phy_op", 32'(phyOp), 32'(sbQ[0].op));
          end
        end
        if (ackCnt >= ackDelay) begin
          phyAck = 1'b1;
          ackCnt = 0;
        end else begin
          ackCnt++;
        end
      end
    end
    if (doneO != '0) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(doneO), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("done_onehot", 32'(doneO), 32'd1 << e.idx);
        checkOutput("err_flags", 32'(errO), e.err ? (32'd1 << e.idx) : 32'd0);
        if (e.lat >= 0) checkOutput("latency", 32'(cycleNo - e.start), 32'(e.lat));
        req[e.idx] = 1'b0;
      end
    end
  endtask

  task automatic waitDone(input int target);
    for (int i = 0; (i < 200) && (doneCount < target); i++) tick();
    checkOutput("done_count", 32'(doneCount), 32'(target));
  endtask

  task automatic applyStimulus(input vec_t v);
    tick();
    ackDelay  = v.ackDelay;
    phyErrVal = v.phyErr;
    ackCnt    = 0;
    typeBus[v.idx*TypeW +: TypeW] = v.typ;
    pageBus[v.idx*PageW +: PageW] = v.page;
    opBus[v.idx*2 +: 2]           = v.op;
    pushExp(v.idx, v.expErr, v.expTouch, v.expLat);
    req[v.idx] = 1'b1;
  endtask

  initial begin
    //          idx type  page   op            ack phyErr expErr touch lat
    vecs[0] = '{0, 2'd0, 4'd9,  InfoOpRead,  0, 1'b0, 1'b0, 1'b1, 4};
    vecs[1] = '{1, 2'd1, 4'd1,  InfoOpRead,  0, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{1, 2'd3, 4'd0,  InfoOpProg,  0, 1'b0, 1'b1, 1'b0, 2};
    vecs[3] = '{2, 2'd2, 4'd1,  InfoOpProg,  5, 1'b1, 1'b1, 1'b1, 9};
    vecs[4] = '{0, 2'd2, 4'd2,  InfoOpErase, 0, 1'b0, 1'b1, 1'b0, 2};
    vecs[5] = '{2, 2'd0, 4'd10, InfoOpRead,  0, 1'b0, 1'b1, 1'b0, 2};
    vecs[6] = '{1, 2'd1, 4'd0,  InfoOpErase, 2, 1'b0, 1'b0, 1'b1, 6};
    vecs[7] = '{2, 2'd0, 4'd15, InfoOpRead,  0, 1'b0, 1'b1, 1'b0, 2};

    tick();
    tick();
    checkOutput("rst_done", 32'(doneO), 32'd0);
    checkOutput("rst_err", 32'(errO), 32'd0);
    checkOutput("rst_phy_req", 32'(phyReq), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutO), 32'd0);
    checkOutput("rst_phy_type", 32'(phyType), 32'd0);
    checkOutput("rst_phy_page", 32'(phyPage), 32'd0);
    checkOutput("rst_phy_op", 32'(phyOp), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitDone(doneCount + 1);
    end

    // Fairness with every requester waiting; requester 0 re-requests after its first turn.
    ackDelay  = 0;
    phyErrVal = 1'b0;
    typeBus   = {2'd0, 2'd2, 2'd0};
    pageBus   = {4'd5, 4'd0, 4'd1};
    opBus     = '0;
    pushExp(0, 1'b0, 1'b1, -1);
    pushExp(1, 1'b0, 1'b1, -1);
    pushExp(2, 1'b0, 1'b1, -1);
    pushExp(0, 1'b0, 1'b1, -1);
    tick();
    req = 3'b111;
    waitDone(doneCount + 1);
    tick();
    req[0] = 1'b1;
    waitDone(doneCount + 3);

    pushExp(2, 1'b0, 1'b1, -1);
    pushExp(0, 1'b0, 1'b1, -1);
    tick();
    req = 3'b101;
    waitDone(doneCount + 2);

    // Reset while the command sits in ISSUE (s=0) and in WAIT (s=1).
    for (int s = 0; s < 2; s++) begin
      ackDelay = (s == 0) ? 1000 : 0;
      noDone   = 1'b1;
      ackCnt   = 0;
      tick();
      typeBus[TypeW +: TypeW] = 2'd0;
      pageBus[PageW +: PageW] = 4'd3;
      req[1] = 1'b1;
      repeat ((s == 0) ? 2 : 3) tick();
      checkOutput("busy_before_rst", 32'(busy), 32'd1);
      checkOutput("phy_req_before_rst", 32'(phyReq), (s == 0) ? 32'd1 : 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("phy_req_async_rst", 32'(phyReq), 32'd0);
      checkOutput("busy_async_rst", 32'(busy), 32'd0);
      checkOutput("done_async_rst", 32'(doneO), 32'd0);
      req     = '0;
      phyAck  = 1'b0;
      phyDone = 1'b0;
      ackCnt  = 0;
      tick();
      rst      = 1'b0;
      noDone   = 1'b0;
      ackDelay = 0;
    end

    typeBus = {2'd0, 2'd2, 2'd0};
    pageBus = {4'd5, 4'd0, 4'd1};
    pushExp(0, 1'b0, 1'b1, -1);
    pushExp(1, 1'b0, 1'b1, -1);
    tick();
    req = 3'b011;
    waitDone(doneCount + 2);

`ifdef FLASH_CTRL_INFO_SCHED_TIMEOUT_EN
    checkOutput("timeout_before", 32'(timeoutO), 32'd0);
    ackDelay = 100000;
    ackCnt   = 0;
    typeBus[0 +: TypeW] = 2'd0;
    pageBus[0 +: PageW] = 4'd2;
    tick();
    pushExp(0, 1'b1, 1'b1, -1);
    req[0] = 1'b1;
    waitDone(doneCount + 1);
    checkOutput("timeout_sticky", 32'(timeoutO), 32'd1);
    ackCnt   = 0;
    ackDelay = 0;
    typeBus[TypeW +: TypeW] = 2'd0;
    pageBus[PageW +: PageW] = 4'd1;
    tick();
    pushExp(1, 1'b1, 1'b0, 2);
    req[1] = 1'b1;
    waitDone(doneCount + 1);
    checkOutput("timeout_still_set", 32'(timeoutO), 32'd1);
`else
    checkOutput("timeout_tied_low", 32'(timeoutO), 32'd0);
`endif

    tick();
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
